// File: rtl/parity_stream_unit.sv
// Handshaked parity generator/checker that folds a wide word CHUNK_W bits per cycle.
// One word in flight at a time; results held until the consumer accepts them.
module parity_stream_unit #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned CHUNK_W = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic              parity_i,
   input  logic              odd_i,
   input  logic              check_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              parity_o,
   output logic              error_o,
   output logic [CNT_W-1:0]  err_cnt_o,
   input  logic              clr_cnt_i,
   output logic              busy_o
);

   localparam int unsigned NBEATS = DATA_W / CHUNK_W;
   localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

   if ((DATA_W % CHUNK_W) != 0) begin : g_width_check
      $error("parity_stream_unit: DATA_W must be a multiple of CHUNK_W");
   end

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e              state_q;
   logic [DATA_W-1:0]   data_q;
   logic [BEAT_W-1:0]   beat_q;
   logic                acc_q;
   logic                parity_in_q;
   logic                odd_q;
   logic                check_q;
   logic                ready_q;
   logic                valid_q;
   logic                parity_q;
   logic                error_q;
   logic [CNT_W-1:0]    err_cnt_q;

   logic                fold_bit;
   logic                acc_next;
   logic                par_next;
   logic [DATA_W-1:0]   data_shift;

   // The captured word is shifted down so the active chunk is always the low slice.
   assign fold_bit = ^data_q[CHUNK_W-1:0];
   assign acc_next = acc_q ^ fold_bit;
   assign par_next = acc_next ^ odd_q;

   if (NBEATS > 1) begin : g_shift
      assign data_shift = {{CHUNK_W{1'b0}}, data_q[DATA_W-1:CHUNK_W]};
   end else begin : g_no_shift
      assign data_shift = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         data_q      <= '0;
         beat_q      <= '0;
         acc_q       <= 1'b0;
         parity_in_q <= 1'b0;
         odd_q       <= 1'b0;
         check_q     <= 1'b0;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         parity_q    <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b1;
               if (valid_i && ready_q) begin
                  data_q      <= data_i;
                  parity_in_q <= parity_i;
                  odd_q       <= odd_i;
                  check_q     <= check_i;
                  acc_q       <= 1'b0;
                  beat_q      <= '0;
                  ready_q     <= 1'b0;
                  state_q     <= StAccum;
               end
            end
            StAccum: begin
               acc_q  <= acc_next;
               data_q <= data_shift;
               beat_q <= beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  parity_q <= par_next;
                  error_q  <= check_q & (par_next != parity_in_q);
                  valid_q  <= 1'b1;
                  state_q  <= StDone;
               end
            end
            StDone: begin
               if (ready_i) begin
                  valid_q  <= 1'b0;
                  parity_q <= 1'b0;
                  error_q  <= 1'b0;
                  ready_q  <= 1'b1;
                  state_q  <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Clear wins over an increment landing on the same edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_q <= '0;
      end else if (clr_cnt_i) begin
         err_cnt_q <= '0;
      end else if ((state_q == StDone) && ready_i && error_q && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign ready_o   = ready_q;
   assign valid_o   = valid_q;
   assign parity_o  = parity_q;
   assign error_o   = error_q;
   assign err_cnt_o = err_cnt_q;
   assign busy_o    = (state_q != StIdle);

endmodule

// File: doc/parity_stream_unit.md
Name: parity_stream_unit

Overview:
Parametrised, handshaked parity generator/checker for wide data words. It folds a DATA_W-bit word CHUNK_W bits per cycle, so wide words reuse narrow reduction logic. It supports even/odd parity per word, and a check mode that compares against a supplied parity bit and keeps a saturating error count. It sits between a producer stream and a consumer stream as a single-word processing stage.

Parameters:
DATA_W, 64, input word width in bits; must be an integer multiple of CHUNK_W (elaboration error otherwise).
CHUNK_W, 16, bits reduced per cycle; NBEATS = DATA_W/CHUNK_W, and NBEATS=1 is legal.
CNT_W, 8, width of the error counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
valid_i  input  1  input word valid.
ready_o  output  1  block can accept a word.
data_i  input  DATA_W  word to process.
parity_i  input  1  expected parity bit; used in check mode only.
odd_i  input  1  0 = even parity, 1 = odd parity.
check_i  input  1  0 = generate, 1 = check.
valid_o  output  1  result valid.
ready_i  input  1  consumer accepts result.
parity_o  output  1  computed parity bit.
error_o  output  1  check-mode mismatch flag.
err_cnt_o  output  CNT_W  saturating count of check errors.
clr_cnt_i  input  1  synchronous clear of err_cnt_o.
busy_o  output  1  high when state is not IDLE.

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-low on rst_ni.
- While rst_ni=0:
  - state=IDLE; ready_o, valid_o, parity_o, error_o, busy_o all 0; err_cnt_o=0.
  - Accumulator, beat index and captured registers cleared.
- ready_o is registered. It rises on the first clk_i edge after rst_ni deasserts, and is 1 only in IDLE.
- FSM states are IDLE, ACCUM and DONE.
- IDLE:
  - Handshake occurs when valid_i & ready_o at a rising edge.
  - On handshake, capture data_i, parity_i, odd_i and check_i; set acc=0, beat=0; go to ACCUM; ready_o->0.
  - Without a handshake, stay in IDLE.
- ACCUM:
  - Each cycle: acc <= acc ^ (XOR-reduce of chunk[beat]), with chunk 0 = bits [CHUNK_W-1:0] first; then beat++.
  - After beat NBEATS-1 is folded, go to DONE.
  - valid_i is ignored here. Input ports may change freely after the handshake; only the captured copies are used.
- DONE:
  - valid_o=1.
  - parity_o = acc ^ odd_q, so data plus parity_o has an even count of ones when odd_q=0 and an odd count when odd_q=1.
  - error_o = check_q & (parity_o != parity_q). error_o=0 in generate mode.
  - Outputs hold stable while ready_i=0 (backpressure of unlimited length).
  - On ready_i=1: go to IDLE; valid_o->0, ready_o->1 on the same edge; parity_o and error_o clear to 0.
- Latency: handshake at edge T gives valid_o=1 after edge T+NBEATS. Minimum spacing between accepted words is NBEATS+2 cycles.
- busy_o=1 in ACCUM and DONE.
- Error counter:
  - Increments by 1 on the DONE->IDLE edge when error_o=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt_i=1 sets the counter to 0 on the next edge, with priority over a same-edge increment.
  - clr_cnt_i is honoured in any state.
- Reset asserted mid-operation (ACCUM or DONE): in-flight word discarded, no valid_o produced, all outputs take their reset values immediately.
- No combinational path from any input to any output.

Test Plan:
- DATA_W=64, CHUNK_W=16, generate, even: data_i=0x0000_0000_0000_0001, handshake at edge T -> valid_o=1 after edge T+4, parity_o=1, error_o=0. Repeat with 0x8000_0000_0000_0000 (last chunk) -> parity_o=1.
- Same data with odd_i=1 -> parity_o=0. data_i=0xFFFF_FFFF_FFFF_FFFF with odd_i=0 -> parity_o=0.
- Check mode: data_i=0xFFFF_FFFF_FFFF_FFFF, parity_i=1, odd_i=0 -> error_o=1, err_cnt_o 0->1 on the ready_i edge. Then parity_i=0 -> error_o=0, count stays 1.
- Backpressure: hold ready_i=0 for 5 cycles in DONE while toggling valid_i/data_i -> valid_o/parity_o held, ready_o=0, no extra word accepted. Then ready_i=1 -> IDLE, ready_o=1 next cycle.
- CNT_W=2: 5 consecutive check errors -> err_cnt_o=3 (saturated). Assert clr_cnt_i on the same edge as a 6th erroring ready_i handshake -> err_cnt_o=0.
- Assert rst_ni=0 in ACCUM beat 2 -> all outputs 0 immediately, no valid_o. After release, ready_o=1 one edge later and the next word 0x0000_0000_0000_0003 yields parity_o=0 correctly.
